press_decoder: RTL

Classifies button activity from the debounced output of the input conditioner into discrete user events: short press, long press, and double click. It sits directly downstream of the conditioner and consumes its `conditioned`, `positiveedge` and `negativeedge` signals. Event outputs are single-cycle registered pulses for the control FSM. A wrapping press counter is also provided for status display.

---
 rtl/press_decoder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/press_decoder.sv
// press_decoder: turns conditioned button activity into short-press,
// long-press and double-click pulses plus a wrapping press counter.
// Optional feature macro: PRESS_DECODER_DOUBLECLICK_EN (double-click detection).
module press_decoder #(
    parameter int unsigned LONGCOUNT = 25000000,
    parameter int unsigned GAPCOUNT  = 15000000,
    parameter int unsigned CNTWIDTH  = 25
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       conditioned,
    input  logic       positiveedge,
    input  logic       negativeedge,
    output logic       shortpress,
    output logic       longpress,
    output logic       doubleclick,
    output logic       held,
    output logic [7:0] presscount
);

    localparam logic [CNTWIDTH-1:0] LONG_LAST = CNTWIDTH'(LONGCOUNT - 1);

    // Reject parameter sets the timer cannot represent.
    if ((64'd1 << CNTWIDTH) <= 64'(LONGCOUNT) || (64'd1 << CNTWIDTH) <= 64'(GAPCOUNT) ||
        LONGCOUNT < 2 || GAPCOUNT < 2) begin : g_param_check
        $error("press_decoder: illegal LONGCOUNT/GAPCOUNT/CNTWIDTH combination");
    end

`ifdef PRESS_DECODER_DOUBLECLICK_EN
    localparam logic [CNTWIDTH-1:0] GAP_LAST = CNTWIDTH'(GAPCOUNT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_LONGHELD,
        ST_WAITGAP,
        ST_PRESSED2
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_LONGHELD
    } state_e;
`endif

    state_e              state_q, state_d;
    logic [CNTWIDTH-1:0] timer_q, timer_d;
    logic                short_q, short_d;
    logic                long_q, long_d;
    logic                held_q, held_d;
    logic [7:0]          count_q, count_d;
`ifdef PRESS_DECODER_DOUBLECLICK_EN
    logic                dbl_q, dbl_d;
`endif

    // Qualified events: simultaneous edges cancel; a press needs the level high,
    // and a low level while pressed stands in for a missed falling edge.
    logic press_ok_c;
    logic release_c;
    assign press_ok_c = positiveedge & ~negativeedge & conditioned;
    assign release_c  = (negativeedge & ~positiveedge) | ~conditioned;

    // Next-state, event and counter logic; releases take priority over timeouts.
    always_comb begin
        state_d = state_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        held_d  = held_q;
        count_d = count_q;
`ifdef PRESS_DECODER_DOUBLECLICK_EN
        dbl_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (press_ok_c) begin
                    state_d = ST_PRESSED;
                    count_d = count_q + 8'd1;
                end
            end
            ST_PRESSED: begin
                if (release_c) begin
`ifdef PRESS_DECODER_DOUBLECLICK_EN
                    state_d = ST_WAITGAP;
`else
                    state_d = ST_IDLE;
                    short_d = 1'b1;
`endif
                end else if (timer_q == LONG_LAST) begin
                    state_d = ST_LONGHELD;
                    long_d  = 1'b1;
                    held_d  = 1'b1;
                end
            end
            ST_LONGHELD: begin
                if (release_c) begin
                    state_d = ST_IDLE;
                    held_d  = 1'b0;
                end
            end
`ifdef PRESS_DECODER_DOUBLECLICK_EN
            ST_WAITGAP: begin
                if (press_ok_c) begin
                    state_d = ST_PRESSED2;
                    count_d = count_q + 8'd1;
                end else if (timer_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                end
            end
            ST_PRESSED2: begin
                if (release_c) begin
                    state_d = ST_IDLE;
                    dbl_d   = 1'b1;
                end else if (timer_q == LONG_LAST) begin
                    state_d = ST_LONGHELD;
                    short_d = 1'b1;
                    long_d  = 1'b1;
                    held_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                held_d  = 1'b0;
            end
        endcase
        timer_d = (state_d != state_q) ? '0 : timer_q + CNTWIDTH'(1);
    end

    // State, timer and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            held_q  <= 1'b0;
            count_q <= 8'd0;
`ifdef PRESS_DECODER_DOUBLECLICK_EN
            dbl_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            short_q <= short_d;
            long_q  <= long_d;
            held_q  <= held_d;
            count_q <= count_d;
`ifdef PRESS_DECODER_DOUBLECLICK_EN
            dbl_q   <= dbl_d;
`endif
        end
    end

    assign shortpress = short_q;
    assign longpress  = long_q;
    assign held       = held_q;
    assign presscount = count_q;
`ifdef PRESS_DECODER_DOUBLECLICK_EN
    assign doubleclick = dbl_q;
`else
    assign doubleclick = 1'b0;
`endif

endmodule
